pdp8_panel_loader: RTL
======================

# pdp8_panel_loader

Synthesizable front-panel sequencer that sits directly upstream of the PDP8 `Top` wrapper. It walks a 4096-word program image through a synchronous read port and emulates an operator at the front panel. For each word it sets the switch register, then pulses Deposit (`btnd`), reloading the address with Load_PC (`btnl`) wherever the image is non-contiguous. When the image is loaded it sets the start PC and raises the run switch `sw[12]`. It replaces the behavioural load loop in emulation builds.

## Interface
- `HOLD_CYCLES`, 10: cycles each panel phase (setup, press, release) is held; legal range 1..255.
- `START_PC`, 12'o0200: PC value loaded before run is raised.
- `LAST_ADDR`, 12'o7777: last image address scanned.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `btnCpuReset`  in  1  reset; one clock, synchronous, active-low.
- `start`  in  1  level; sampled in IDLE/DONE, begins a load sequence.
- `img_addr`  out  12  image read address.
- `img_data`  in  12  image word, valid exactly 1 cycle after `img_addr` is presented.
- `sw`  out  13  to `Top.sw`; [11:0] switch register, [12] run.
- `btnd`  out  1  Deposit button to `Top`.
- `btnl`  out  1  Load_PC / load-address button to `Top`.
- `busy`  out  1  high in every state except IDLE and DONE.
- `done`  out  1  high in DONE.
- `dep_count`  out  13  number of Deposit pulses issued this sequence.

## Operation
- States: IDLE, READ, CHECK, ADDR_SET, ADDR_PRESS, ADDR_REL, DATA_SET, DATA_PRESS, DATA_REL, PC_SET, PC_PRESS, PC_REL, DONE.
- Internal regs: `scan` (12b image index), `next_dep` (12b, address the PDP8 deposit pointer holds), `need_addr` flag, `phase_cnt` (8b).
- IDLE and `start`=1: go to READ.
  - Clear `scan`, `dep_count`, `sw`.
  - Set `need_addr`=1.
- READ: drive `img_addr`=`scan`. Go to CHECK next cycle.
- CHECK (`img_data` valid):
  - Word is skipped (see Configuration): set `need_addr`=1. If `scan`==LAST_ADDR go to PC_SET, else `scan`+1 and go to READ.
  - Else if `need_addr`: go to ADDR_SET. Else go to DATA_SET.
- ADDR_SET / ADDR_PRESS / ADDR_REL: drive `sw[11:0]`=`scan` in all three. `btnl`=1 only in ADDR_PRESS. At the end set `next_dep`=`scan` and clear `need_addr`.
- DATA_SET / DATA_PRESS / DATA_REL: drive `sw[11:0]`=latched `img_data` in all three. `btnd`=1 only in DATA_PRESS.
- At DATA_REL end:
  - `dep_count`+1 and `next_dep`+1 (mod 4096).
  - If `scan`==LAST_ADDR go to PC_SET, else `scan`+1 and go to READ.
- PC_SET / PC_PRESS / PC_REL: drive `sw[11:0]`=START_PC. `btnl`=1 only in PC_PRESS. At the end go to DONE.
- DONE: `sw[12]`=1, `sw[11:0]` hold START_PC, `done`=1.
  - `start`=1 in DONE: clear `sw[12]` and restart exactly as from IDLE.
- `start` is ignored while `busy`. `btnd` and `btnl` are never high in the same cycle.
- The `scan` wrap from 4095 to 0 never occurs; LAST_ADDR terminates the scan.

## Timing
- Reset (`btnCpuReset`=0 at an edge), values on the following edge:
  - state=IDLE
  - `sw`=0, `btnd`=0, `btnl`=0
  - `img_addr`=0
  - `busy`=0, `done`=0, `dep_count`=0
- Reset mid-sequence aborts immediately; a pressed button is released on that edge.
- Each SET/PRESS/REL state lasts exactly HOLD_CYCLES cycles; `phase_cnt` reloads on every state entry.
- Read latency: READ 1 cycle + CHECK 1 cycle.
- Per contiguous deposited word: 2 + 3·HOLD_CYCLES cycles. An address reload adds 3·HOLD_CYCLES.
- Skipped word: 2 cycles.
- The `sw[11:0]` value is stable from the first SET cycle through the last REL cycle of its group.
- `start`→`busy`: 1 cycle.
- `done` rises 1 cycle after the PC_REL last cycle.

## Configuration
- `PANEL_SKIP_ZERO_EN` defined:
  - Words equal to 12'o0000 are skipped.
  - The next non-zero word is preceded by an address reload, so memory contents remain address-correct.
- Undefined:
  - No word is skipped; every address 0..LAST_ADDR is deposited.
  - Exactly one address reload occurs, at address 0.
  - `dep_count` ends at LAST_ADDR+1.

## Test plan
- HOLD_CYCLES=10, skip-zero on; image: [0]=0o7200, [1]=0o1234, rest 0.
  - Expect: 1 ADDR group (sw=0), 2 deposits of 0o7200 and 0o1234, then PC load 0o0200.
  - Expect: `done`, `sw[12]`=1, `dep_count`=2.
- Skip-zero on; non-zero words only at 0o200 and 0o205.
  - Expect: two ADDR groups with sw=0o0200 and sw=0o0205 respectively, `dep_count`=2.
  - Expect: end-to-end `Top` memory matches the image.
- Skip-zero off; LAST_ADDR=3; image 1,2,3,4.
  - Expect: 1 ADDR group, 4 deposits, total cycles 4·(2+30)+30+30 from `start`.
- Assert reset during DATA_PRESS.
  - Expect next edge: `btnd`=0, `sw`=0, `busy`=0.
  - Expect: a subsequent `start` reruns from address 0.
- `start` pulsed while busy: no effect. `start` in DONE: `sw[12]` drops on the next edge and the sequence reruns.
- Throughout every run: assert `btnd`&`btnl` never both high, and `sw[11:0]` never changes while either button is high.

Source files
------------

// File: rtl/pdp8_panel_loader_if.sv
// Purpose: bundles the loader's image read port, start control and front-panel outputs.
// Latency: none, wiring only.
// Backpressure: none; img_data must follow img_addr by exactly one cycle.
interface pdp8_panel_loader_if;
    logic        start;
    logic [11:0] img_addr;
    logic [11:0] img_data;
    logic [12:0] sw;
    logic        btnd;
    logic        btnl;
    logic        busy;
    logic        done;
    logic [12:0] dep_count;

    // The loader drives the panel and the image address.
    modport master (
        input  start,
        input  img_data,
        output img_addr,
        output sw,
        output btnd,
        output btnl,
        output busy,
        output done,
        output dep_count
    );

    // Image memory and the PDP8 panel side.
    modport slave (
        output start,
        output img_data,
        input  img_addr,
        input  sw,
        input  btnd,
        input  btnl,
        input  busy,
        input  done,
        input  dep_count
    );
endinterface

// File: rtl/pdp8_panel_loader.sv
// Purpose: walks a program image and plays it into the PDP8 front panel (switches, Deposit, Load_PC), then sets PC and run.
// Latency: 2 cycles per word read, plus 3*HOLD_CYCLES per panel group (address, data, PC).
// Backpressure: none; start is ignored while busy. Define PANEL_SKIP_ZERO_EN to skip all-zero words.
module pdp8_panel_loader #(
    parameter int          HOLD_CYCLES = 10,       // legal 1..255
    parameter logic [11:0] START_PC    = 12'o0200,
    parameter logic [11:0] LAST_ADDR   = 12'o7777
) (
    input  logic                        clk,
    input  logic                        btnCpuReset,
    pdp8_panel_loader_if.master         bus
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_READ,
        S_CHECK,
        S_ADDR_SET,
        S_ADDR_PRESS,
        S_ADDR_REL,
        S_DATA_SET,
        S_DATA_PRESS,
        S_DATA_REL,
        S_PC_SET,
        S_PC_PRESS,
        S_PC_REL,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      state;
    logic [11:0] scan;
    logic [11:0] next_dep;
    logic        need_addr;
    logic [7:0]  phase_cnt;
    logic [11:0] data_q;

    logic [11:0] img_addr;
    logic [12:0] sw;
    logic        btnd;
    logic        btnl;
    logic        busy;
    logic        done;
    logic [12:0] dep_count;

    logic        phase_end;
    logic        skip_word;
    logic        at_last;

    assign phase_end = (phase_cnt == 8'd0);
    assign at_last   = (scan == LAST_ADDR);

`ifdef PANEL_SKIP_ZERO_EN
    // Empty words are not deposited; the next real word forces an address reload.
    assign skip_word = (bus.img_data == 12'o0000);
`else
    assign skip_word = 1'b0;
`endif

    assign bus.img_addr  = img_addr;
    assign bus.sw        = sw;
    assign bus.btnd      = btnd;
    assign bus.btnl      = btnl;
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.dep_count = dep_count;

    // Panel sequencer: every output is registered and updated on state entry/exit.
    always_ff @(posedge clk) begin
        if (!btnCpuReset) begin
            state     <= S_IDLE;
            scan      <= 12'd0;
            next_dep  <= 12'd0;
            need_addr <= 1'b1;
            phase_cnt <= 8'd0;
            data_q    <= 12'd0;
            img_addr  <= 12'd0;
            sw        <= 13'd0;
            btnd      <= 1'b0;
            btnl      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dep_count <= 13'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        state     <= S_READ;
                        scan      <= 12'd0;
                        img_addr  <= 12'd0;
                        dep_count <= 13'd0;
                        sw        <= 13'd0;
                        need_addr <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end

                S_READ: begin
                    state <= S_CHECK;
                end

                S_CHECK: begin
                    data_q <= bus.img_data;
                    if (skip_word) begin
                        need_addr <= 1'b1;
                        if (at_last) begin
                            state     <= S_PC_SET;
                            sw[11:0]  <= START_PC;
                            phase_cnt <= HOLD_LAST;
                        end else begin
                            state    <= S_READ;
                            scan     <= scan + 12'd1;
                            img_addr <= scan + 12'd1;
                        end
                    end else if (need_addr || (next_dep != scan)) begin
                        // The PDP8 deposit pointer is not at this word: reload it first.
                        state     <= S_ADDR_SET;
                        sw[11:0]  <= scan;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        state     <= S_DATA_SET;
                        sw[11:0]  <= bus.img_data;
                        phase_cnt <= HOLD_LAST;
                    end
                end

                S_ADDR_SET: begin
                    if (phase_end) begin
                        state     <= S_ADDR_PRESS;
                        btnl      <= 1'b1;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_ADDR_PRESS: begin
                    if (phase_end) begin
                        state     <= S_ADDR_REL;
                        btnl      <= 1'b0;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_ADDR_REL: begin
                    if (phase_end) begin
                        state     <= S_DATA_SET;
                        next_dep  <= scan;
                        need_addr <= 1'b0;
                        sw[11:0]  <= data_q;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_DATA_SET: begin
                    if (phase_end) begin
                        state     <= S_DATA_PRESS;
                        btnd      <= 1'b1;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_DATA_PRESS: begin
                    if (phase_end) begin
                        state     <= S_DATA_REL;
                        btnd      <= 1'b0;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_DATA_REL: begin
                    if (phase_end) begin
                        dep_count <= dep_count + 13'd1;
                        next_dep  <= next_dep + 12'd1;
                        if (at_last) begin
                            state     <= S_PC_SET;
                            sw[11:0]  <= START_PC;
                            phase_cnt <= HOLD_LAST;
                        end else begin
                            state    <= S_READ;
                            scan     <= scan + 12'd1;
                            img_addr <= scan + 12'd1;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_PC_SET: begin
                    if (phase_end) begin
                        state     <= S_PC_PRESS;
                        btnl      <= 1'b1;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_PC_PRESS: begin
                    if (phase_end) begin
                        state     <= S_PC_REL;
                        btnl      <= 1'b0;
                        phase_cnt <= HOLD_LAST;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                S_PC_REL: begin
                    if (phase_end) begin
                        state  <= S_DONE;
                        sw[12] <= 1'b1;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt - 8'd1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    btnd  <= 1'b0;
                    btnl  <= 1'b0;
                end
            endcase
        end
    end

endmodule
